// File: rtl/rr_left_arbiter_pkg.sv
// Shared types and helpers for the registered left/round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of the hold counter: enough for MAX_HOLD, never less than one bit.
  function automatic int hold_cnt_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_left_arbiter_if.sv
// Request/grant bundle between request collection and the phase controller.
interface rr_left_arbiter_if #(
  parameter int N = 9
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    req;
  logic            mode_rr;
  logic            release_in;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            timeout;

  modport master (
    output req, mode_rr, release_in,
    input  grant, grant_valid, grant_idx, timeout
  );

  modport slave (
    input  req, mode_rr, release_in,
    output grant, grant_valid, grant_idx, timeout
  );
endinterface

// File: rtl/rr_left_arbiter_pick.sv
// Combinational leftmost (highest index) one-hot picker, N requesters.
module left_arbiter_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant
);

  // Scan from the MSB down and keep only the first set bit.
  always_comb begin : pick_left
    logic v_found;
    v_found = 1'b0;
    o_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i] && !v_found) begin
        o_grant[i] = 1'b1;
        v_found    = 1'b1;
      end else begin
        o_grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rr_left_arbiter.sv
// Registered N-way arbiter: fixed-left or round-robin, grant held until
// release, request drop, or hold timeout.
module rr_left_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 9,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               reset,
  rr_left_arbiter_if.slave   bus
);

  localparam int IDXW = $clog2(N);
  localparam int CW   = hold_cnt_width(MAX_HOLD);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD);

  arb_state_e      r_state, w_state_nx;
  logic [N-1:0]    r_grant, w_grant_nx;
  logic            r_valid, w_valid_nx;
  logic [IDXW-1:0] r_idx, w_idx_nx;
  logic            r_timeout, w_timeout_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [IDXW-1:0] r_ptr, w_ptr_nx;

  logic [N-1:0]    w_mask, w_req_masked, w_pick_masked, w_pick_full, w_winner;
  logic [IDXW-1:0] w_win_idx;
  logic            w_held_req, w_normal_exit, w_limit, w_exit;

  // Round-robin window: only indices strictly below the last winner.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i < int'(r_ptr));
    end
  end

  assign w_req_masked = bus.req & w_mask;

  left_arbiter_n #(.N(N)) u_pick_masked (
    .i_req   (w_req_masked),
    .o_grant (w_pick_masked)
  );

  left_arbiter_n #(.N(N)) u_pick_full (
    .i_req   (bus.req),
    .o_grant (w_pick_full)
  );

  // Masked pick wins in RR mode when anything is below ptr; otherwise wrap.
  always_comb begin
    if ((bus.mode_rr == MODE_RR) && (|w_pick_masked)) begin
      w_winner = w_pick_masked;
    end else begin
      w_winner = w_pick_full;
    end
  end

  // One-hot winner to binary index.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_winner[i]) begin
        w_win_idx = i[IDXW-1:0];
      end else begin
        w_win_idx = w_win_idx;
      end
    end
  end

  assign w_held_req    = |(bus.req & r_grant);
  assign w_normal_exit = bus.release_in | ~w_held_req;
  assign w_limit       = (MAX_HOLD != 0) && (r_cnt == LIMIT);
  assign w_exit        = w_normal_exit | w_limit;

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_valid_nx   = r_valid;
    w_idx_nx     = r_idx;
    w_cnt_nx     = r_cnt;
    w_ptr_nx     = r_ptr;
    w_timeout_nx = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nx = GRANT;
          w_grant_nx = w_winner;
          w_valid_nx = 1'b1;
          w_idx_nx   = w_win_idx;
          w_cnt_nx   = CW'(1);
          w_ptr_nx   = w_win_idx;
        end else begin
          w_state_nx = IDLE;
          w_grant_nx = '0;
          w_valid_nx = 1'b0;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
        end
      end
      GRANT: begin
        if (w_exit) begin
          w_state_nx   = IDLE;
          w_grant_nx   = '0;
          w_valid_nx   = 1'b0;
          w_idx_nx     = '0;
          w_cnt_nx     = '0;
          w_timeout_nx = w_limit & ~w_normal_exit;
        end else if (r_cnt != {CW{1'b1}}) begin
          w_cnt_nx = r_cnt + CW'(1);
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
        w_valid_nx = 1'b0;
        w_idx_nx   = '0;
        w_cnt_nx   = '0;
        w_ptr_nx   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_valid   <= w_valid_nx;
      r_idx     <= w_idx_nx;
      r_timeout <= w_timeout_nx;
      r_cnt     <= w_cnt_nx;
      r_ptr     <= w_ptr_nx;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_valid;
  assign bus.grant_idx   = r_idx;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_rr_left_arbiter.sv
// Self-checking bench: behavioural model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_rr_left_arbiter;

  localparam int N    = 9;
  localparam int MAXH = 4;

  logic clk;
  logic tb_reset;
  int   n_cmp;
  int   n_bad;

  rr_left_arbiter_if #(.N(N)) bus ();

  rr_left_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .reset (tb_reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference pick straight from the arbitration rules.
  function automatic int ref_pick(input logic [N-1:0] r, input logic rr, input int ptr);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr - k + N) % N;
        if (r[j]) return j;
      end
    end
    return 0;
  endfunction

  // Behavioural model state.
  bit m_armed = 1'b0;
  bit m_busy  = 1'b0;
  int m_g     = 0;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;
  bit m_norm;
  bit m_lim;

  // Model update on each rising edge, compare shortly after it.
  initial begin
    forever begin
      @(posedge clk);
      if (tb_reset) begin
        m_armed = 1'b1; m_busy = 1'b0; m_held = 0; m_ptr = 0; m_to = 1'b0; m_g = 0;
      end else if (!m_busy) begin
        m_to = 1'b0;
        if (bus.req != '0) begin
          m_g    = ref_pick(bus.req, bus.mode_rr, m_ptr);
          m_busy = 1'b1;
          m_held = 1;
          m_ptr  = m_g;
        end
      end else begin
        m_norm = bus.release_in || !bus.req[m_g];
        m_lim  = (MAXH != 0) && (m_held == MAXH);
        if (m_norm || m_lim) begin
          m_busy = 1'b0;
          m_to   = !m_norm;
        end else begin
          m_held++;
          m_to = 1'b0;
        end
      end
      #1;
      if (m_armed) begin
        chk("model_grant", int'(bus.grant), m_busy ? (1 << m_g) : 0);
        chk("model_valid", int'(bus.grant_valid), int'(m_busy));
        chk("model_idx", int'(bus.grant_idx), m_busy ? m_g : 0);
        chk("model_timeout", int'(bus.timeout), int'(m_to));
      end
    end
  end

  // Apply inputs at the current falling edge, return at the next one.
  task automatic tick(input logic rst, input logic [N-1:0] r, input logic m, input logic rl);
    tb_reset       = rst;
    bus.req        = r;
    bus.mode_rr    = m;
    bus.release_in = rl;
    @(negedge clk);
  endtask

  int rr_exp[5] = '{8, 2, 0, 8, 2};
  logic [N-1:0] rnd_req;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    tb_reset = 1'b1;
    bus.req = '0;
    bus.mode_rr = 1'b0;
    bus.release_in = 1'b0;
    @(negedge clk);
    tick(1'b1, 9'h000, 1'b0, 1'b0);
    tick(1'b1, 9'h000, 1'b0, 1'b0);
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_valid", int'(bus.grant_valid), 0);
    chk("reset_idx", int'(bus.grant_idx), 0);
    chk("reset_timeout", int'(bus.timeout), 0);

    // Fixed priority, release after 3 grant cycles.
    tick(1'b0, 9'h029, 1'b0, 1'b0);
    chk("fixed_idx", int'(bus.grant_idx), 5);
    chk("fixed_grant", int'(bus.grant), 9'h020);
    tick(1'b0, 9'h029, 1'b0, 1'b0);
    tick(1'b0, 9'h029, 1'b0, 1'b0);
    chk("fixed_hold3", int'(bus.grant_idx), 5);
    tick(1'b0, 9'h029, 1'b0, 1'b1);
    chk("fixed_dead", int'(bus.grant_valid), 0);
    tick(1'b0, 9'h029, 1'b0, 1'b0);
    chk("fixed_regrant", int'(bus.grant_idx), 5);
    tick(1'b0, 9'h000, 1'b0, 1'b1);
    tick(1'b0, 9'h000, 1'b0, 1'b0);

    // Round-robin order from a fresh pointer.
    tick(1'b1, 9'h000, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 9'h105, 1'b1, 1'b0);
      chk("rr_order", int'(bus.grant_idx), rr_exp[k]);
      tick(1'b0, 9'h105, 1'b1, 1'b1);
      chk("rr_dead", int'(bus.grant_valid), 0);
    end
    tick(1'b0, 9'h000, 1'b0, 1'b0);

    // Hold timeout.
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 9'h008, 1'b0, 1'b0);
      chk("to_hold", int'(bus.grant), 9'h008);
      chk("to_quiet", int'(bus.timeout), 0);
    end
    tick(1'b0, 9'h008, 1'b0, 1'b0);
    chk("to_cleared", int'(bus.grant_valid), 0);
    chk("to_pulse", int'(bus.timeout), 1);
    tick(1'b0, 9'h008, 1'b0, 1'b0);
    chk("to_regrant", int'(bus.grant_idx), 3);
    chk("to_pulse_end", int'(bus.timeout), 0);

    // Release coinciding with the limit is a normal exit.
    tick(1'b0, 9'h008, 1'b0, 1'b0);
    tick(1'b0, 9'h008, 1'b0, 1'b0);
    tick(1'b0, 9'h008, 1'b0, 1'b0);
    tick(1'b0, 9'h008, 1'b0, 1'b1);
    chk("rel_lim_valid", int'(bus.grant_valid), 0);
    chk("rel_lim_timeout", int'(bus.timeout), 0);
    tick(1'b0, 9'h000, 1'b0, 1'b0);

    // Request drop and no preemption.
    tick(1'b0, 9'h080, 1'b0, 1'b0);
    chk("drop_grant", int'(bus.grant_idx), 7);
    tick(1'b0, 9'h180, 1'b0, 1'b0);
    chk("no_preempt", int'(bus.grant_idx), 7);
    tick(1'b0, 9'h100, 1'b0, 1'b0);
    chk("drop_clear", int'(bus.grant_valid), 0);
    tick(1'b0, 9'h000, 1'b0, 1'b0);

    // Reset in the middle of a grant.
    tick(1'b0, 9'h040, 1'b1, 1'b0);
    chk("mid_rst_pre", int'(bus.grant_idx), 6);
    tick(1'b1, 9'h040, 1'b1, 1'b0);
    chk("mid_rst_grant", int'(bus.grant), 0);
    chk("mid_rst_timeout", int'(bus.timeout), 0);
    tick(1'b0, 9'h1FF, 1'b1, 1'b0);
    chk("mid_rst_ptr", int'(bus.grant_idx), 8);
    tick(1'b0, 9'h000, 1'b0, 1'b1);

    // Randomised traffic, checked by the model every cycle.
    rnd_req = 9'h000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd_req = N'($urandom_range(0, 511) & $urandom_range(0, 511));
      end
      tick(($urandom_range(0, 99) == 0), rnd_req,
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    tick(1'b0, 9'h000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_left_arbiter.md
Name: rr_left_arbiter

Overview:
- Parametrised, registered successor to the fixed-width 4/9-bit left (MSB-first) one-hot arbiters.
- Arbitrates N request lines (traffic phases, pedestrian, emergency sources) in one of two modes: fixed left priority or round-robin.
- Holds a grant until the requester releases, its request drops, or a hold timeout expires.
- Sits between the request-collection logic and the phase/timer controller.

Parameters:
- N, 9, number of requesters; N >= 2.
- MAX_HOLD, 15, maximum number of grant cycles before forced release; 0 disables the timeout.
- IDXW, $clog2(N), derived width of grant_idx. Not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit N-1 is leftmost (highest fixed priority).
- mode_rr  input  1  arbitration mode: 0 = fixed left priority, 1 = round-robin. Sampled only in IDLE.
- release  input  1  current holder finished; ignored in IDLE.
- grant  output  N  one-hot grant; all zeros when no grant.
- grant_valid  output  1  high exactly when grant is nonzero.
- grant_idx  output  IDXW  binary index of the granted bit; 0 when not valid.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While reset is high at a rising edge, the next state is:
  - state = IDLE
  - grant = 0, grant_valid = 0, grant_idx = 0, timeout = 0
  - hold counter = 0
  - RR pointer = 0
- Reset mid-grant clears the grant at that edge; no timeout pulse is produced.
- All outputs are registered. There is no combinational path from inputs to outputs.
- State IDLE:
  - If req != 0 at an edge, register the winner and go to GRANT with hold counter = 1. Grant appears one cycle after the request is sampled.
  - If req == 0, stay in IDLE with outputs at zero.
- Winner selection, fixed mode (mode_rr = 0): highest set index of req.
- Winner selection, round-robin mode (mode_rr = 1):
  - Pick the first set bit scanning downward from ptr-1, wrapping from 0 to N-1. ptr itself is checked last.
  - Reset ptr = 0, so the first search starts at N-1 and matches fixed mode.
- ptr update: ptr loads the winner index on every IDLE-to-GRANT transition, in both modes.
- State GRANT, with g = granted index:
  - Exit to IDLE if release = 1, or req[g] = 0, or (MAX_HOLD != 0 and counter == MAX_HOLD).
  - On exit, grant, grant_valid and grant_idx clear at that edge. There is exactly one dead IDLE cycle between consecutive grants; no back-to-back grant.
  - Otherwise stay in GRANT and increment the counter. The counter saturates and does not wrap. Width is $clog2(MAX_HOLD+1), minimum 1.
- Grant duration: at most MAX_HOLD cycles when MAX_HOLD != 0.
- Timeout rule:
  - timeout = 1 for the single cycle after an exit caused only by the counter limit.
  - If release = 1 or req[g] = 0 coincides with the limit, the exit is normal and timeout stays 0.
- Request bits other than g do not preempt the grant.
- mode_rr changes during GRANT take effect at the next IDLE arbitration.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - When grant_valid = 1, grant[grant_idx] = 1.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, GRANT}
  - mode constants MODE_FIXED = 1'b0, MODE_RR = 1'b1
- Sub-module left_arbiter_n (parameter N): combinational leftmost-one-hot picker, the generic form of the 4/9-bit left arbiters.
- Round-robin is built from two instances:
  - Instance 1 picks from req masked to indices < ptr.
  - Instance 2 picks from the unmasked req.
  - Use the masked result if it is nonzero, else the unmasked result.
  - Fixed mode uses instance 2 only.
- One-hot-to-index encoding is done in the top module.

Test Plan:
- Fixed mode, N=9, req = 9'b0_0010_1001 held:
  - Grant = bit 5 (grant_idx = 5) one cycle after sampling.
  - Release after 3 cycles gives one dead cycle, then bit 5 again.
- Round-robin, req = 9'b1_0000_0101 constant, release pulsed each grant:
  - Grant order is 8, 2, 0, 8, 2, with one idle cycle between grants.
- Timeout, MAX_HOLD = 4, fixed mode, req[3] held, release = 0:
  - grant[3] is high for exactly 4 cycles, then a timeout pulse for 1 cycle, then re-grant of 3.
- Release at limit, MAX_HOLD = 4, release = 1 in the 4th grant cycle:
  - Grant clears and timeout stays 0.
- Request drop and no preemption:
  - req[7] drops while granted: grant clears next edge.
  - req[8] rising during a grant to 7 does not preempt.
- Reset during GRANT (grant_idx = 6):
  - Next edge gives all outputs 0 and ptr = 0.
  - The following round-robin arbitration with req = 9'h1FF grants 8.
